ddr3_writer_framebuf: RTL and testbench

//  Write side of the DDR3 frame buffer: takes a stream of 256-bit pixel words (16 px x 16 b),

---
 rtl/ddr3_fb_pkg.sv | 36 +++
 rtl/ddr3_writer_framebuf.sv | 150 +++++++++++++++
 tb/tb_ddr3_writer_framebuf.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_fb_pkg.sv
// Shared frame-buffer layout constants and writer state encoding.
// The strip readers use the same derived constants so both sides agree on the layout.
package ddr3_fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_BURST    = 2'd2
  } wr_state_e;

  localparam int unsigned DefInWidth        = 16;
  localparam int unsigned DefFrameFullWidth = 768;
  localparam int unsigned DefFrameLines     = 480;
  localparam int unsigned DefBurstLen       = 4;

  function automatic int unsigned pixels_per_wr_f(input int unsigned in_width);
    return 256 / in_width;
  endfunction

  function automatic int unsigned full_line_len_f(input int unsigned in_width,
                                                  input int unsigned full_width);
    return full_width / pixels_per_wr_f(in_width);
  endfunction

  function automatic int unsigned frame_words_f(input int unsigned in_width,
                                                input int unsigned full_width,
                                                input int unsigned lines);
    return full_line_len_f(in_width, full_width) * lines;
  endfunction

  localparam int unsigned PixelsPerWr = pixels_per_wr_f(DefInWidth);
  localparam int unsigned FullLineLen = full_line_len_f(DefInWidth, DefFrameFullWidth);
  localparam int unsigned FrameWords  = frame_words_f(DefInWidth, DefFrameFullWidth,
                                                      DefFrameLines);

endpackage

// File: rtl/ddr3_writer_framebuf.sv
// Writes one SOF-aligned frame of 256-bit pixel words linearly into DDR3 via Avalon-MM bursts.
// Data path is a pass-through; control is a single FSM with word/beat counters.
module ddr3_writer_framebuf
  import ddr3_fb_pkg::*;
#(
  parameter int unsigned InWidth        = DefInWidth,
  parameter int unsigned FrameFullWidth = DefFrameFullWidth,
  parameter int unsigned FrameLines     = DefFrameLines,
  parameter int unsigned BurstLen       = DefBurstLen
) (
  input  logic         ddr3clk,
  input  logic         ddr3clk_reset,
  input  logic [26:0]  start_data,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [255:0] in_data,
  input  logic         in_sof,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [26:0]  ddr3_address,
  output logic [255:0] ddr3_writedata,
  output logic         ddr3_write,
  output logic [3:0]   ddr3_burstcount,
  output logic [31:0]  ddr3_byteenable,
  input  logic         ddr3_waitrequest,
  output logic         frame_done,
  output logic         sof_error,
  output logic         busy
);

  localparam int unsigned FrameWordsP = frame_words_f(InWidth, FrameFullWidth, FrameLines);
  localparam logic [14:0] LastWord    = 15'(FrameWordsP - 1);
  localparam logic [2:0]  LastBeat    = 3'(BurstLen - 1);
  localparam logic [26:0] AddrStep    = 27'(BurstLen);

  wr_state_e   state_q, state_d;
  logic [26:0] base_q, base_d;
  logic [26:0] addr_q, addr_d;
  logic [14:0] word_cnt_q, word_cnt_d;
  logic [2:0]  beat_cnt_q, beat_cnt_d;
  logic        frame_done_q, frame_done_d;
  logic        sof_error_q, sof_error_d;
  logic        resync_q, resync_d;

  logic in_burst, sof_restart, beat_acc, last_beat, pend_now;

  assign in_burst = (state_q == ST_BURST);
  // SOF on a burst boundary mid-frame: hold the word and restart the frame at base.
  assign sof_restart = in_burst && in_valid && in_sof && (beat_cnt_q == 3'd0) &&
                       (word_cnt_q != 15'd0);
  assign ddr3_write  = in_burst && in_valid && !sof_restart;
  assign beat_acc    = ddr3_write && !ddr3_waitrequest;
  assign last_beat   = (beat_cnt_q == LastBeat);
  // SOF inside a burst: burst still has to finish, resync after its last beat.
  assign pend_now    = resync_q || (in_sof && (beat_cnt_q != 3'd0));

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      ST_WAIT_SOF: in_ready = in_valid && !in_sof;
      ST_BURST:    in_ready = beat_acc;
      default:     in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    addr_d       = addr_q;
    word_cnt_d   = word_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    resync_d     = resync_q;
    frame_done_d = 1'b0;
    sof_error_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          base_d     = start_data;
          addr_d     = start_data;
          word_cnt_d = 15'd0;
          beat_cnt_d = 3'd0;
          resync_d   = 1'b0;
          state_d    = ST_WAIT_SOF;
        end
      end
      ST_WAIT_SOF: begin
        if (in_valid && in_sof) state_d = ST_BURST;
      end
      ST_BURST: begin
        if (sof_restart) begin
          addr_d      = base_q;
          word_cnt_d  = 15'd0;
          sof_error_d = 1'b1;
        end else if (beat_acc) begin
          word_cnt_d = word_cnt_q + 15'd1;
          beat_cnt_d = beat_cnt_q + 3'd1;
          resync_d   = pend_now;
          if (last_beat) begin
            beat_cnt_d = 3'd0;
            addr_d     = addr_q + AddrStep;
            if (word_cnt_q == LastWord) begin
              frame_done_d = 1'b1;
              resync_d     = 1'b0;
              state_d      = ST_IDLE;
            end else if (pend_now) begin
              sof_error_d = 1'b1;
              resync_d    = 1'b0;
              addr_d      = base_q;
              word_cnt_d  = 15'd0;
              state_d     = ST_WAIT_SOF;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ddr3clk or posedge ddr3clk_reset) begin
    if (ddr3clk_reset) begin
      state_q      <= ST_IDLE;
      base_q       <= 27'd0;
      addr_q       <= 27'd0;
      word_cnt_q   <= 15'd0;
      beat_cnt_q   <= 3'd0;
      resync_q     <= 1'b0;
      frame_done_q <= 1'b0;
      sof_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      addr_q       <= addr_d;
      word_cnt_q   <= word_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      resync_q     <= resync_d;
      frame_done_q <= frame_done_d;
      sof_error_q  <= sof_error_d;
    end
  end

  assign start_ready     = (state_q == ST_IDLE);
  assign busy            = (state_q != ST_IDLE);
  assign ddr3_address    = addr_q;
  assign ddr3_writedata  = in_data;
  assign ddr3_burstcount = 4'(BurstLen);
  assign ddr3_byteenable = '1;
  assign frame_done      = frame_done_q;
  assign sof_error       = sof_error_q;

endmodule

// File: tb/tb_ddr3_writer_framebuf.sv
// Bench for ddr3_writer_framebuf: random streams checked against a word-index model of the
// frame layout (address = base + burst-aligned word index).
module tb_ddr3_writer_framebuf;

  localparam int FW = 23040;
  localparam int BL = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [26:0]  start_data;
  logic         start_valid;
  logic         start_ready;
  logic [255:0] in_data;
  logic         in_sof;
  logic         in_valid;
  logic         in_ready;
  logic [26:0]  ddr3_address;
  logic [255:0] ddr3_writedata;
  logic         ddr3_write;
  logic [3:0]   ddr3_burstcount;
  logic [31:0]  ddr3_byteenable;
  logic         ddr3_waitrequest;
  logic         frame_done;
  logic         sof_error;
  logic         busy;

  ddr3_writer_framebuf dut (
    .ddr3clk          (clk),
    .ddr3clk_reset    (rst),
    .start_data       (start_data),
    .start_valid      (start_valid),
    .start_ready      (start_ready),
    .in_data          (in_data),
    .in_sof           (in_sof),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .ddr3_address     (ddr3_address),
    .ddr3_writedata   (ddr3_writedata),
    .ddr3_write       (ddr3_write),
    .ddr3_burstcount  (ddr3_burstcount),
    .ddr3_byteenable  (ddr3_byteenable),
    .ddr3_waitrequest (ddr3_waitrequest),
    .frame_done       (frame_done),
    .sof_error        (sof_error),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [255:0] src_d[$];
  bit           src_s[$];
  logic [255:0] exp_data[$];
  logic [26:0]  exp_addr[$];
  int           exp_err;
  int           exp_done;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [255:0] rnd_word();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic push_words(input int n, input bit first_sof);
    for (int i = 0; i < n; i++) begin
      src_d.push_back(rnd_word());
      src_s.push_back(first_sof && (i == 0));
    end
  endtask

  // Frame rules in word-index terms: wait for SOF, word k lands at base + BL*(k/BL);
  // SOF on a burst boundary restarts at index 0, SOF mid-burst finishes the burst then resyncs.
  task automatic build_model(input logic [26:0] base);
    int idx = 0;
    bit sync = 0;
    bit resync = 0;
    exp_data.delete();
    exp_addr.delete();
    exp_err  = 0;
    exp_done = 0;
    foreach (src_d[i]) begin
      if (!sync) begin
        if (!src_s[i]) continue;
        sync = 1;
        idx  = 0;
      end else if (src_s[i] && idx != 0 && !resync) begin
        if (idx % BL == 0) begin
          exp_err++;
          idx = 0;
        end else begin
          resync = 1;
        end
      end
      exp_data.push_back(src_d[i]);
      exp_addr.push_back(base + 27'(BL * (idx / BL)));
      idx++;
      if (idx == FW) begin
        exp_done++;
        break;
      end
      if (resync && idx % BL == 0) begin
        exp_err++;
        resync = 0;
        sync   = 0;
        idx    = 0;
      end
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    start_valid = 1'b0;
    start_data = '0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_data = '0;
    ddr3_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input logic [26:0] base, input int wait_pct, input int gap_pct,
                            input int budget);
    int  cycles = 0;
    int  drain = 0;
    int  done_n = 0;
    int  err_n = 0;
    bit  consumed;
    build_model(base);
    start_data  = base;
    start_valid = 1'b1;
    @(negedge clk);
    check("start_ready", 256'(start_ready), 256'(1));
    @(posedge clk);
    #1 start_valid = 1'b0;
    start_data = '0;
    in_valid = 1'b0;
    while (drain < 8 && cycles < budget) begin
      if (!in_valid && src_d.size() > 0 && $urandom_range(99) >= gap_pct) begin
        in_valid = 1'b1;
        in_data  = src_d[0];
        in_sof   = src_s[0];
      end
      ddr3_waitrequest = ($urandom_range(99) < wait_pct);
      @(negedge clk);
      consumed = in_valid && in_ready;
      if (ddr3_write && !ddr3_waitrequest) begin
        check("beat_expected", 256'(exp_data.size() != 0), 256'(1));
        if (exp_data.size() != 0) begin
          check("wr_data", ddr3_writedata, exp_data.pop_front());
          check("wr_addr", 256'(ddr3_address), 256'(exp_addr.pop_front()));
          check("burstcount", 256'(ddr3_burstcount), 256'(BL));
          check("byteenable", 256'(ddr3_byteenable), 256'(32'hFFFF_FFFF));
        end
      end
      if (frame_done) done_n++;
      if (sof_error) err_n++;
      @(posedge clk);
      #1;
      if (consumed) begin
        void'(src_d.pop_front());
        void'(src_s.pop_front());
        in_valid = 1'b0;
        in_sof   = 1'b0;
      end
      if (src_d.size() == 0 && !in_valid) drain++;
      cycles++;
    end
    ddr3_waitrequest = 1'b0;
    in_valid = 1'b0;
    check("cycle_budget", 256'(cycles < budget), 256'(1));
    check("beats_missing", 256'(exp_data.size()), 256'(0));
    check("frame_done_cnt", 256'(done_n), 256'(exp_done));
    check("sof_error_cnt", 256'(err_n), 256'(exp_err));
  endtask

  initial begin
    reset_dut();

    // Reset state
    @(negedge clk);
    check("rst_address", 256'(ddr3_address), 256'(0));
    check("rst_write", 256'(ddr3_write), 256'(0));
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_frame_done", 256'(frame_done), 256'(0));
    check("rst_sof_error", 256'(sof_error), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_start_ready", 256'(start_ready), 256'(1));
    @(posedge clk);
    #1;

    // Full frame at 0x100, no stalls
    src_d.delete(); src_s.delete();
    push_words(FW, 1'b1);
    run_stream(27'h100, 0, 0, 30000);
    check("full_busy_after", 256'(busy), 256'(0));
    check("full_last_addr_next", 256'(ddr3_address), 256'(27'h100 + 27'(FW)));

    // Three non-SOF words dropped ahead of SOF
    reset_dut();
    src_d.delete(); src_s.delete();
    push_words(3, 1'b0);
    push_words(8, 1'b1);
    run_stream(27'h2000, 0, 0, 200);

    // SOF at word 42 (mid-burst), resync, next SOF at base
    reset_dut();
    src_d.delete(); src_s.delete();
    push_words(42, 1'b1);
    push_words(2, 1'b1);
    push_words(2, 1'b0);
    push_words(4, 1'b1);
    run_stream(27'h100, 10, 10, 500);
    check("mid_sof_busy", 256'(busy), 256'(1));

    // Random stalls and gaps, SOF at word 40 restarts, then a complete frame
    reset_dut();
    src_d.delete(); src_s.delete();
    push_words(40, 1'b1);
    push_words(FW, 1'b1);
    run_stream(27'(($urandom() & 32'h3FF_FF00)), 30, 15, 60000);
    check("rand_busy_after", 256'(busy), 256'(0));

    // Async reset mid-burst
    reset_dut();
    start_data = 27'h200;
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    in_valid = 1'b1;
    in_sof = 1'b1;
    in_data = rnd_word();
    @(posedge clk);
    @(posedge clk);
    #1 in_sof = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_write", 256'(ddr3_write), 256'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_write", 256'(ddr3_write), 256'(0));
    check("mid_rst_in_ready", 256'(in_ready), 256'(0));
    check("mid_rst_busy", 256'(busy), 256'(0));
    check("mid_rst_address", 256'(ddr3_address), 256'(0));
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_start_ready", 256'(start_ready), 256'(1));
    check("post_rst_busy", 256'(busy), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
